// File: rtl/fetch_stage.sv
// rtl/fetch_stage.sv - instruction fetch and fixed-period sequencing stage
module fetch_stage #(
  parameter int          STALL_CYCLES = 5,
  parameter int          WB_CYCLE     = 4,
  parameter logic [31:0] PC_RESET     = 32'h00400020
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        nPC_sel,
  input  logic [15:0] imm16,
  input  logic        halt,
  input  logic [31:0] imem_data,
  output logic [31:0] imem_adr,
  output logic [31:0] inst,
  output logic [31:0] pc,
  output logic        wr_strobe,
  output logic        pc_update,
  output logic [31:0] retired
);

  localparam logic [3:0] LAST_PH = 4'(STALL_CYCLES);
  localparam logic [3:0] WB_PH   = 4'(WB_CYCLE);

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    EXEC   = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  ph_q, ph_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] retired_q, retired_d;
  logic [31:0] branch_off;

  assign branch_off = {{14{imm16[15]}}, imm16, 2'b00};

  always_comb begin
    state_d   = state_q;
    ph_d      = ph_q;
    pc_d      = pc_q;
    inst_d    = inst_q;
    retired_d = retired_q;
    wr_strobe = 1'b0;
    pc_update = 1'b0;

    case (state_q)
      FETCH: begin
        inst_d  = imem_data;
        ph_d    = 4'd1;
        state_d = EXEC;
      end
      EXEC: begin
        if (ph_q == LAST_PH) begin
          pc_update = 1'b1;
          pc_d      = pc_q + 32'd4 + (nPC_sel ? branch_off : 32'd0);
          retired_d = retired_q + 32'd1;
          ph_d      = 4'd0;
          state_d   = halt ? HALTED : FETCH;
        end else begin
          wr_strobe = (ph_q == WB_PH);
          ph_d      = ph_q + 4'd1;
        end
      end
      HALTED: begin
        ph_d = 4'd0;
        if (!halt) begin
          state_d = FETCH;
        end
      end
      default: begin
        ph_d    = 4'd0;
        state_d = FETCH;
      end
    endcase

    // A reset cycle must never let a write or PC advance escape downstream.
    if (rst) begin
      wr_strobe = 1'b0;
      pc_update = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= FETCH;
      ph_q      <= 4'd0;
      pc_q      <= PC_RESET;
      inst_q    <= 32'h00000000;
      retired_q <= 32'd0;
    end else begin
      state_q   <= state_d;
      ph_q      <= ph_d;
      pc_q      <= pc_d;
      inst_q    <= inst_d;
      retired_q <= retired_d;
    end
  end

  assign imem_adr = pc_q;
  assign pc       = pc_q;
  assign inst     = inst_q;
  assign retired  = retired_q;

endmodule
